// File: rtl/alu_unit.sv
// alu_unit: execute stage for the 8 x 16-bit register bank.
// Single-cycle ADD/SUB/AND/OR/XOR/SHL; iterative MUL (shift-add) and
// DIV (restoring) taking WIDTH steps with a start/busy handshake.
// A single 2*WIDTH working register is shared: for MUL it holds
// {partial product high, multiplier/product low}, for DIV it holds
// {partial remainder, dividend/quotient}.
module alu_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] srcreg1,
  input  logic [WIDTH-1:0] srcreg2,
  input  logic [2:0]       destreg_in,
  output logic [WIDTH-1:0] ALU_result,
  output logic [2:0]       destreg_sel,
  output logic             result_valid,
  output logic             busy,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero
);

  localparam int LW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic {IDLE, ITER} state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic [2:0]           dst_q, dst_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [2:0]           dsel_q, dsel_d;
  logic                 rv_q, rv_d;
  logic                 z_q, z_d;
  logic                 c_q, c_d;
  logic                 v_q, v_d;
  logic                 dz_q, dz_d;

  // single-cycle datapath
  logic [WIDTH:0]       add_w, sub_w;
  logic [2*WIDTH-1:0]   shl_w;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v;

  // iterative datapath
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_trial;
  logic [2*WIDTH-1:0]   div_next;
  logic                 last_step;

  // Single-cycle operations and their flags, straight from the operand ports.
  always_comb begin
    add_w   = {1'b0, srcreg1} + {1'b0, srcreg2};
    sub_w   = {1'b0, srcreg1} - {1'b0, srcreg2};
    // Shifting into a double-width word leaves the last bit shifted out at
    // bit WIDTH, which is naturally 0 for a zero shift amount.
    shl_w   = {{WIDTH{1'b0}}, srcreg1} << srcreg2[LW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (srcreg1[WIDTH-1] == srcreg2[WIDTH-1]) &&
                  (add_w[WIDTH-1] != srcreg1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];               // borrow: A < B unsigned
        alu_v   = (srcreg1[WIDTH-1] != srcreg2[WIDTH-1]) &&
                  (sub_w[WIDTH-1] != srcreg1[WIDTH-1]);
      end
      OP_AND: alu_res = srcreg1 & srcreg2;
      OP_OR:  alu_res = srcreg1 | srcreg2;
      OP_XOR: alu_res = srcreg1 ^ srcreg2;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  // One MUL step and one DIV step computed from the working register.
  always_comb begin
    // MUL: add multiplicand into the high half when the current multiplier
    // LSB is set, then shift the whole pair right by one.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    // DIV: shift the next dividend bit into the remainder, trial-subtract
    // the divisor, keep the difference only if it did not borrow. A zero
    // divisor never borrows, so the quotient comes out all-ones.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, b_q};
    if (!div_trial[WIDTH+1])
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    last_step = (cnt_q == LW'(WIDTH - 1));
  end

  // Next-state and output-register logic for the IDLE/ITER controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    dst_d   = dst_q;
    acc_d   = acc_q;
    res_d   = res_q;
    dsel_d  = dsel_q;
    rv_d    = 1'b0;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (opcode[2:1] == 2'b11) begin
            a_d     = srcreg1;
            b_d     = srcreg2;
            op_d    = opcode;
            dst_d   = destreg_in;
            acc_d   = (opcode == OP_MUL) ? {{WIDTH{1'b0}}, srcreg2}
                                         : {{WIDTH{1'b0}}, srcreg1};
            cnt_d   = '0;
            state_d = ITER;
          end else begin
            res_d  = alu_res;
            dsel_d = destreg_in;
            z_d    = (alu_res == '0);
            c_d    = alu_c;
            v_d    = alu_v;
            dz_d   = 1'b0;
            rv_d   = 1'b1;
          end
        end
      end
      ITER: begin
        acc_d = (op_q == OP_MUL) ? mul_next : div_next;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          if (op_q == OP_MUL) begin
            res_d = mul_next[WIDTH-1:0];
            c_d   = |mul_next[2*WIDTH-1:WIDTH];
            dz_d  = 1'b0;
            z_d   = (mul_next[WIDTH-1:0] == '0);
          end else begin
            res_d = div_next[WIDTH-1:0];
            c_d   = 1'b0;
            dz_d  = (b_q == '0);
            z_d   = (div_next[WIDTH-1:0] == '0);
          end
          v_d     = 1'b0;
          dsel_d  = dst_q;
          rv_d    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset also aborts an in-flight MUL/DIV.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      dsel_q  <= '0;
      rv_q    <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      dsel_q  <= dsel_d;
      rv_q    <= rv_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      dz_q    <= dz_d;
    end
  end

  assign ALU_result   = res_q;
  assign destreg_sel  = dsel_q;
  assign result_valid = rv_q;
  assign busy         = (state_q == ITER);
  assign zero         = z_q;
  assign carry        = c_q;
  assign overflow     = v_q;
  assign div_zero     = dz_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit at WIDTH=16.
module tb_alu_unit;

  localparam int W = 16;

  logic         clk, rst, start;
  logic [2:0]   opcode, destreg_in, destreg_sel;
  logic [W-1:0] srcreg1, srcreg2, ALU_result;
  logic         result_valid, busy, zero, carry, overflow, div_zero;

  int errs   = 0;
  int checks = 0;
  int strobes = 0;
  int lat, s0;

  alu_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .srcreg1(srcreg1), .srcreg2(srcreg2), .destreg_in(destreg_in),
    .ALU_result(ALU_result), .destreg_sel(destreg_sel),
    .result_valid(result_valid), .busy(busy), .zero(zero),
    .carry(carry), .overflow(overflow), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counts strobe cycles; sampled value is the pre-edge result_valid
  always @(posedge clk) if (result_valid) strobes <= strobes + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive a one-cycle request at the current negedge; return at the next negedge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b, input logic [2:0] d);
    start = 1'b1; opcode = op; srcreg1 = a; srcreg2 = b; destreg_in = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat=1 is the cycle after the request edge
  task automatic wait_rv(input int from, output int l);
    l = from;
    while (!result_valid && l < 40) begin
      @(negedge clk);
      l++;
    end
    if (!result_valid) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_flags(input string tag, input logic z, c, v, dz);
    chk({tag, ".zero"}, 32'(zero), 32'(z));
    chk({tag, ".carry"}, 32'(carry), 32'(c));
    chk({tag, ".ovf"}, 32'(overflow), 32'(v));
    chk({tag, ".dz"}, 32'(div_zero), 32'(dz));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; srcreg1 = '0; srcreg2 = '0; destreg_in = '0;
    repeat (3) @(negedge clk);
    chk("rst.res", 32'(ALU_result), 32'h0);
    chk("rst.rv", 32'(result_valid), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ADD overflow, strobe one cycle after start
    issue(3'b000, 16'h7FFF, 16'h0001, 3'd1);
    chk("add.rv", 32'(result_valid), 32'h1);
    chk("add.res", 32'(ALU_result), 32'h8000);
    chk("add.dst", 32'(destreg_sel), 32'h1);
    chk("add.busy", 32'(busy), 32'h0);
    chk_flags("add", 1'b0, 1'b0, 1'b1, 1'b0);

    // reset mid-MUL at iteration 5: no strobe, outputs cleared
    issue(3'b110, 16'h00FF, 16'h00FF, 3'd6);
    s0 = strobes;
    chk("rmul.busy", 32'(busy), 32'h1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmul.res", 32'(ALU_result), 32'h0);
    chk("rmul.dst", 32'(destreg_sel), 32'h0);
    chk("rmul.rv", 32'(result_valid), 32'h0);
    chk("rmul.busy", 32'(busy), 32'h0);
    chk_flags("rmul", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("rmul.nostrobe", 32'(strobes - s0), 32'h0);

    // SUB borrow
    issue(3'b001, 16'h0003, 16'h0005, 3'd2);
    chk("sub.rv", 32'(result_valid), 32'h1);
    chk("sub.res", 32'(ALU_result), 32'hFFFE);
    chk_flags("sub", 1'b0, 1'b1, 1'b0, 1'b0);

    // SHL carry-out
    issue(3'b101, 16'h8001, 16'h0001, 3'd3);
    chk("shl.res", 32'(ALU_result), 32'h0002);
    chk_flags("shl", 1'b0, 1'b1, 1'b0, 1'b0);

    // SHL by zero: carry must be 0
    issue(3'b101, 16'h8001, 16'h0010, 3'd3);
    chk("shl0.res", 32'(ALU_result), 32'h8001);
    chk("shl0.carry", 32'(carry), 32'h0);

    // XOR zero result
    issue(3'b100, 16'hAAAA, 16'hAAAA, 3'd4);
    chk("xor.res", 32'(ALU_result), 32'h0000);
    chk_flags("xor", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("xor.single", 32'(result_valid), 32'h0);

    // back-to-back ADD then OR
    start = 1'b1; opcode = 3'b000; srcreg1 = 16'h0001; srcreg2 = 16'h0002; destreg_in = 3'd1;
    @(negedge clk);
    chk("b2b.rv0", 32'(result_valid), 32'h1);
    chk("b2b.res0", 32'(ALU_result), 32'h0003);
    chk("b2b.dst0", 32'(destreg_sel), 32'h1);
    opcode = 3'b011; srcreg1 = 16'h00F0; srcreg2 = 16'h000F; destreg_in = 3'd2;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.rv1", 32'(result_valid), 32'h1);
    chk("b2b.res1", 32'(ALU_result), 32'h00FF);
    chk("b2b.dst1", 32'(destreg_sel), 32'h2);
    @(negedge clk);
    chk("b2b.rv2", 32'(result_valid), 32'h0);

    // MUL, 17-cycle latency
    issue(3'b110, 16'h0123, 16'h0045, 3'd5);
    chk("mul1.busy", 32'(busy), 32'h1);
    chk("mul1.rv", 32'(result_valid), 32'h0);
    wait_rv(1, lat);
    chk("mul1.lat", 32'(lat), 32'd17);
    chk("mul1.res", 32'(ALU_result), 32'h4E6F);
    chk("mul1.dst", 32'(destreg_sel), 32'h5);
    chk("mul1.busy0", 32'(busy), 32'h0);
    chk_flags("mul1", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // MUL with nonzero high half
    issue(3'b110, 16'h1234, 16'h0100, 3'd6);
    wait_rv(1, lat);
    chk("mul2.res", 32'(ALU_result), 32'h3400);
    chk("mul2.carry", 32'(carry), 32'h1);
    @(negedge clk);

    // DIV 1000/7
    issue(3'b111, 16'd1000, 16'd7, 3'd7);
    wait_rv(1, lat);
    chk("div1.lat", 32'(lat), 32'd17);
    chk("div1.res", 32'(ALU_result), 32'h008E);
    chk("div1.dst", 32'(destreg_sel), 32'h7);
    chk_flags("div1", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // DIV by zero
    issue(3'b111, 16'h1234, 16'h0000, 3'd2);
    wait_rv(1, lat);
    chk("div0.lat", 32'(lat), 32'd17);
    chk("div0.res", 32'(ALU_result), 32'hFFFF);
    chk_flags("div0", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    // busy handshake: ADD start and operand change mid-DIV are ignored
    s0 = strobes;
    issue(3'b111, 16'd1000, 16'd7, 3'd3);
    repeat (3) @(negedge clk);
    start = 1'b1; opcode = 3'b000; srcreg1 = 16'hFFFF; srcreg2 = 16'h0001; destreg_in = 3'd1;
    @(negedge clk);
    start = 1'b0;
    chk("hs.busy", 32'(busy), 32'h1);
    chk("hs.norv", 32'(result_valid), 32'h0);
    wait_rv(5, lat);
    chk("hs.lat", 32'(lat), 32'd17);
    chk("hs.res", 32'(ALU_result), 32'h008E);
    chk("hs.dst", 32'(destreg_sel), 32'h3);
    repeat (3) @(negedge clk);
    chk("hs.strobes", 32'(strobes - s0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Execute stage feeding the 8-entry, 16-bit register bank. Takes the two source operands read from the bank, performs one of eight operations, and returns the result on `ALU_result` together with the destination register select and a one-cycle write strobe. Logic and add/shift operations finish in one cycle. Multiply and divide run as iterative shift-add and restoring-division sequences over WIDTH cycles, with a start/busy handshake back to control.

## Interface
- `WIDTH`, 16: operand/result width; must be ≥4 and a power of two; iteration count = WIDTH.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only while `busy`=0.
- `opcode` in 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 DIV.
- `srcreg1` in WIDTH: operand A (dividend, multiplicand).
- `srcreg2` in WIDTH: operand B (divisor, multiplier; SHL amount = `srcreg2[log2(WIDTH)-1:0]`).
- `destreg_in` in 3: destination register index for this request.
- `ALU_result` out WIDTH: registered result.
- `destreg_sel` out 3: registered destination index, aligned with `ALU_result`.
- `result_valid` out 1: one-cycle write strobe for the register bank.
- `busy` out 1: high while a MUL/DIV is iterating.
- `zero`, `carry`, `overflow`, `div_zero` out 1 each: status flags, registered.

## Operation
- Reset values: `ALU_result`=0, `destreg_sel`=0, `result_valid`=0, `busy`=0, all flags 0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE, ITER.
  - IDLE with `start`=1 and opcode 000–101: compute, register result/flags/dest, pulse `result_valid`, stay in IDLE.
  - IDLE with `start`=1 and opcode 110/111: latch A, B, opcode, and dest; clear accumulator/remainder; counter=0; go to ITER; `busy`=1.
  - ITER: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. The step with counter=WIDTH-1 loads the outputs, pulses `result_valid`, clears `busy`, and returns to IDLE.
- Operand and opcode changes while `busy`=1 are ignored. `start` while `busy`=1 is dropped, with no queueing.
- Arithmetic, unsigned modulo 2^WIDTH unless stated:
  - ADD: `carry` = carry-out; `overflow` = signed overflow.
  - SUB: A−B; `carry` = borrow (A<B unsigned); `overflow` = signed overflow.
  - AND/OR/XOR: `carry`=`overflow`=0.
  - SHL: A << amt; `carry` = last bit shifted out, 0 when amt=0.
  - MUL: low WIDTH bits of the 2·WIDTH product; `carry`=1 if the high half is nonzero.
  - DIV: unsigned quotient. Divisor 0 yields quotient all-ones, the natural restoring result, with `div_zero`=1 and full latency. The remainder is discarded.
- `zero` = (result==0) for every opcode. `div_zero`=0 except for DIV by zero.
- Flags, `ALU_result`, and `destreg_sel` update only on the cycle `result_valid` is asserted and otherwise hold.
- `rst` during ITER aborts the operation: no `result_valid`, all outputs return to reset values next cycle.

## Timing
- `start` sampled at edge k, ops 000–101: outputs valid and `result_valid`=1 for the cycle after edge k; `busy` never rises.
- `start` sampled at edge k, MUL/DIV: `busy`=1 after edge k. The result loads at edge k+WIDTH, so `result_valid`=1 and `busy`=0 in the cycle after edge k+WIDTH. Latency is WIDTH+1 cycles from request to strobe, 17 at WIDTH=16.
- Back-to-back: a `start` presented in the cycle where `result_valid`=1 and `busy`=0 is accepted. Single-cycle ops sustain one result per clock.
- `result_valid` is never high for two consecutive cycles from a single request.

## Test plan
- Reset mid-MUL: start MUL 0x00FF×0x00FF, assert `rst` at iteration 5 → no `result_valid`; all outputs 0, `busy`=0 next cycle.
- ADD/SUB:
  - ADD 0x7FFF+0x0001 → 0x8000, `overflow`=1, `carry`=0, strobe 1 cycle after start.
  - SUB 0x0003−0x0005 → 0xFFFE, `carry`=1.
- Logic/shift:
  - SHL 0x8001 by 1 → 0x0002, `carry`=1.
  - XOR 0xAAAA^0xAAAA → 0x0000, `zero`=1.
  - Back-to-back ADD, OR on consecutive cycles → two consecutive strobes with correct `destreg_sel`.
- MUL:
  - 0x0123×0x0045 → 0x4E6F, `carry`=0, `result_valid` exactly 17 cycles after start.
  - 0x1234×0x0100 → 0x3400, `carry`=1.
- DIV:
  - 1000/7 → 0x008E.
  - 0x1234/0 → 0xFFFF, `div_zero`=1, same 17-cycle latency.
- Busy handshake: pulse `start` with ADD at iteration 3 of a DIV, and change `srcreg1` mid-DIV → ADD ignored, DIV result unchanged, only one strobe.
